// File: rtl/alu_multicycle_exec.sv
// Execution unit for the multicycle datapath: single-cycle ALU ops plus
// bit-serial shifts, behind a valid/ready handshake on both sides.
module alu_multicycle_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   zero_o,
    output logic                   overflow_o,
    output logic                   illegal_op_o
);
    localparam int HALF = DATA_WIDTH / 2;
    localparam int MSB  = DATA_WIDTH - 1;

    localparam logic [3:0] OP_LUI = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_work;
    logic                   r_left;

    logic [DATA_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0]  w_diff;
    logic [DATA_WIDTH-1:0]  w_res;
    logic                   w_ovf;
    logic                   w_ill;
    logic                   w_is_shift;
    logic                   w_start_shift;
    logic                   w_shift_last;
    logic [DATA_WIDTH-1:0]  w_work_nxt;

    assign w_sum  = a_i + b_i;
    assign w_diff = a_i - b_i;

    assign w_is_shift    = (alu_operation_i == OP_SLL) ||
                           (alu_operation_i == OP_SRL);
    assign w_start_shift = w_is_shift && (shamt_i != '0);
    assign w_shift_last  = (r_cnt == SHAMT_WIDTH'(1));
    assign w_work_nxt    = r_left ? (r_work << 1) : (r_work >> 1);

    // Shift ops only reach this path with shamt == 0, so they pass b through.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (alu_operation_i)
            OP_LUI: w_res = {b_i[HALF-1:0], {HALF{1'b0}}};
            OP_OR:  w_res = a_i | b_i;
            OP_SLL: w_res = b_i;
            OP_SRL: w_res = b_i;
            OP_AND: w_res = a_i & b_i;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a_i[MSB] == b_i[MSB]) && (w_sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a_i[MSB] != b_i[MSB]) && (w_diff[MSB] != a_i[MSB]);
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_next = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_work       <= '0;
            r_left       <= 1'b0;
            result_o     <= '0;
            zero_o       <= 1'b0;
            overflow_o   <= 1'b0;
            illegal_op_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i && w_start_shift) begin
                        r_cnt  <= shamt_i;
                        r_work <= b_i;
                        r_left <= (alu_operation_i == OP_SLL);
                    end else if (in_valid_i) begin
                        result_o     <= w_res;
                        zero_o       <= (w_res == '0);
                        overflow_o   <= w_ovf;
                        illegal_op_o <= w_ill;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
                    if (w_shift_last) begin
                        result_o     <= w_work_nxt;
                        zero_o       <= (w_work_nxt == '0);
                        overflow_o   <= 1'b0;
                        illegal_op_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o     = (r_state == S_IDLE);
    assign result_valid_o = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Self-checking bench for alu_multicycle_exec: latency-level reference model
// checked every cycle, directed literal cases, then randomized operations.
module tb_alu_multicycle_exec;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  shamt_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;
    logic        illegal_op_o;

    int checks = 0;
    int errors = 0;

    alu_multicycle_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o),
        .illegal_op_o    (illegal_op_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation table.
    function automatic void ref_calc(input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh,
                                     output logic [31:0] r,
                                     output logic o, output logic il);
        longint s;
        r = 32'h0; o = 1'b0; il = 1'b0; s = 0;
        case (op)
            4'd0: r = {b[15:0], 16'h0000};
            4'd1: r = a | b;
            4'd2: r = b << sh;
            4'd3: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: r = b >> sh;
            4'd5: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: r = a & b;
            default: il = 1'b1;
        endcase
    endfunction

    // Model: idle/ready, edges left before result, result pending.
    logic        m_init = 1'b0;
    logic        m_ready;
    logic        m_valid;
    int          m_left;
    logic [31:0] m_res;
    logic        m_ovf;
    logic        m_ill;

    always @(posedge clk) begin
        if (reset) begin
            m_init  = 1'b1;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_init) begin
            if (m_ready && in_valid_i) begin
                ref_calc(alu_operation_i, a_i, b_i, shamt_i, m_res, m_ovf, m_ill);
                m_ready = 1'b0;
                if ((alu_operation_i == 4'd2 || alu_operation_i == 4'd4) &&
                    shamt_i != 5'd0)
                    m_left = int'(shamt_i);
                else
                    m_valid = 1'b1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_valid = 1'b1;
            end else if (m_valid && result_ready_i) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model in_ready", {31'b0, in_ready_o}, {31'b0, m_ready});
            chk("model result_valid", {31'b0, result_valid_o}, {31'b0, m_valid});
            if (m_valid) begin
                chk("model result", result_o, m_res);
                chk("model zero", {31'b0, zero_o}, {31'b0, (m_res == 32'h0)});
                chk("model overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
                chk("model illegal", {31'b0, illegal_op_o}, {31'b0, m_ill});
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input int hold,
                          input logic [31:0] e_res, input int e_lat,
                          input logic e_z, input logic e_o, input logic e_i);
        int n;
        int lat;
        n = 0;
        result_ready_i = 1'b0;
        while (!in_ready_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({name, " ready timeout"}, {31'b0, in_ready_o}, 32'd1);
        in_valid_i      = 1'b1;
        alu_operation_i = op;
        a_i             = a;
        b_i             = b;
        shamt_i         = sh;
        @(posedge clk); #1;
        in_valid_i      = 1'b0;
        alu_operation_i = 4'($urandom);
        a_i             = $urandom;
        b_i             = $urandom;
        shamt_i         = 5'($urandom);
        chk({name, " busy"}, {31'b0, in_ready_o}, 32'd0);
        lat = 1;
        while (!result_valid_o && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, " latency"}, lat, e_lat);
        chk({name, " result"}, result_o, e_res);
        chk({name, " zero"}, {31'b0, zero_o}, {31'b0, e_z});
        chk({name, " overflow"}, {31'b0, overflow_o}, {31'b0, e_o});
        chk({name, " illegal"}, {31'b0, illegal_op_o}, {31'b0, e_i});
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk({name, " held valid"}, {31'b0, result_valid_o}, 32'd1);
            chk({name, " held result"}, result_o, e_res);
        end
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        chk({name, " ready after"}, {31'b0, in_ready_o}, 32'd1);
        chk({name, " valid after"}, {31'b0, result_valid_o}, 32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic [4:0]  sh;
        logic        o, il;
        int          lat;

        reset = 1'b1; in_valid_i = 1'b0; result_ready_i = 1'b0;
        alu_operation_i = 4'd0; a_i = '0; b_i = '0; shamt_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'b0, in_ready_o}, 32'd1);
        chk("reset valid", {31'b0, result_valid_o}, 32'd0);
        chk("reset result", result_o, 32'h0);
        chk("reset zero", {31'b0, zero_o}, 32'd0);
        chk("reset overflow", {31'b0, overflow_o}, 32'd0);
        chk("reset illegal", {31'b0, illegal_op_o}, 32'd0);
        reset = 1'b0;

        run_op("add", 4'd3, 32'd7, 32'd5, 5'd0, 0, 32'd12, 1, 0, 0, 0);
        run_op("sub ovf", 4'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0,
               32'h8000_0000, 1, 0, 1, 0);
        run_op("add ovf", 4'd3, 32'h7FFF_FFFF, 32'd1, 5'd0, 0,
               32'h8000_0000, 1, 0, 1, 0);
        run_op("sub zero", 4'd5, 32'd5, 32'd5, 5'd0, 0, 32'h0, 1, 1, 0, 0);
        run_op("sll 31", 4'd2, 32'h0, 32'd1, 5'd31, 0, 32'h8000_0000, 32, 0, 0, 0);
        run_op("srl 4", 4'd4, 32'h0, 32'h8000_0000, 5'd4, 0,
               32'h0800_0000, 5, 0, 0, 0);
        run_op("sll 0", 4'd2, 32'h0, 32'h0000_ABCD, 5'd0, 0,
               32'h0000_ABCD, 1, 0, 0, 0);
        run_op("or hold", 4'd1, 32'hF0, 32'h0F, 5'd0, 5, 32'hFF, 1, 0, 0, 0);
        run_op("illegal", 4'b1001, 32'd3, 32'd4, 5'd0, 0, 32'h0, 1, 1, 0, 1);
        run_op("lui", 4'd0, 32'h0, 32'h1234, 5'd0, 0, 32'h1234_0000, 1, 0, 0, 0);

        // Abort a long shift with reset partway through.
        in_valid_i = 1'b1; alu_operation_i = 4'd2; b_i = 32'd1; shamt_i = 5'd20;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort valid", {31'b0, result_valid_o}, 32'd0);
        chk("abort in_ready", {31'b0, in_ready_o}, 32'd1);
        repeat (30) begin
            @(posedge clk); #1;
            chk("abort no stale", {31'b0, result_valid_o}, 32'd0);
        end
        run_op("add after abort", 4'd3, 32'd1, 32'd1, 5'd0, 0, 32'd2, 1, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15))
                                             : 4'($urandom_range(0, 6));
            a  = pick_val();
            b  = pick_val();
            sh = 5'($urandom);
            ref_calc(op, a, b, sh, r, o, il);
            lat = ((op == 4'd2 || op == 4'd4) && sh != 5'd0) ? int'(sh) + 1 : 1;
            run_op("random", op, a, b, sh, $urandom_range(0, 3), r, lat,
                   (r == 32'h0), o, il);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
